seq_detector_param: RTL and testbench



---
 rtl/seq_detector_param.sv | 89 ++++++++
 tb/tb_seq_detector_param.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Serial sequence recogniser: compares the last N sampled bits of X against a
// runtime-loadable pattern, flags matches on Z and keeps a saturating match count.
module seq_detector_param #(
  parameter int unsigned  N         = 3,
  parameter logic [N-1:0] RESET_PAT = 3'b110,
  parameter bit           OVERLAP   = 1'b1,
  parameter int unsigned  CW        = 8
) (
  input  logic          CK,
  input  logic          RESET,
  input  logic          EN,
  input  logic          X,
  input  logic          LOAD_PAT,
  input  logic [N-1:0]  PAT_IN,
  input  logic          CLR_CNT,
  output logic          Z,
  output logic [CW-1:0] MATCH_CNT,
  output logic          CNT_SAT
);

  localparam int unsigned FW = $clog2(N + 1);
  localparam logic [FW-1:0] FillFull = FW'(N);
  localparam logic [FW-1:0] FillHit  = FW'(N - 1);

  logic [N-1:0]  pat_q, pat_d;
  logic [N-1:0]  hist_q, hist_d;
  logic [FW-1:0] fill_q, fill_d;
  logic          z_q, z_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sat_q, sat_d;
  logic [N-1:0]  nxt;
  logic          hit;

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    hit    = 1'b0;
    nxt    = {hist_q[N-2:0], X};

    if (LOAD_PAT) begin
      pat_d  = PAT_IN;
      hist_d = '0;
      fill_d = '0;
    end else if (EN) begin
      // The fill gate keeps the cleared history from matching an all-zero pattern.
      hit    = (fill_q >= FillHit) && (nxt == pat_q);
      hist_d = nxt;
      fill_d = (fill_q == FillFull) ? fill_q : fill_q + 1'b1;
      if (!OVERLAP && hit) begin
        hist_d = '0;
        fill_d = '0;
      end
    end

    z_d = hit;

    if (CLR_CNT) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
    sat_d = (cnt_d == '1);
  end

  always_ff @(posedge CK) begin
    if (RESET) begin
      pat_q  <= RESET_PAT;
      hist_q <= '0;
      fill_q <= '0;
      z_q    <= 1'b0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      z_q    <= z_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
    end
  end

  assign Z         = z_q;
  assign MATCH_CNT = cnt_q;
  assign CNT_SAT   = sat_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: overlapping, non-overlapping and
// narrow-counter instances driven from one shared stimulus stream.
module tb_seq_detector_param;

  logic       CK = 1'b0;
  logic       RESET = 1'b1;
  logic       EN = 1'b0;
  logic       X = 1'b0;
  logic       LOAD_PAT = 1'b0;
  logic [2:0] PAT_IN = 3'b000;
  logic       CLR_CNT = 1'b0;

  logic       za, zb, zc;
  logic [7:0] cnta, cntb;
  logic [1:0] cntc;
  logic       sata, satb, satc;

  int passed = 0;
  int total  = 0;

  always #5 CK = ~CK;

  seq_detector_param #(.N(3), .RESET_PAT(3'b110), .OVERLAP(1'b1), .CW(8)) u_a (
    .CK(CK), .RESET(RESET), .EN(EN), .X(X), .LOAD_PAT(LOAD_PAT), .PAT_IN(PAT_IN),
    .CLR_CNT(CLR_CNT), .Z(za), .MATCH_CNT(cnta), .CNT_SAT(sata)
  );

  seq_detector_param #(.N(3), .RESET_PAT(3'b110), .OVERLAP(1'b0), .CW(8)) u_b (
    .CK(CK), .RESET(RESET), .EN(EN), .X(X), .LOAD_PAT(LOAD_PAT), .PAT_IN(PAT_IN),
    .CLR_CNT(CLR_CNT), .Z(zb), .MATCH_CNT(cntb), .CNT_SAT(satb)
  );

  seq_detector_param #(.N(2), .RESET_PAT(2'b11), .OVERLAP(1'b1), .CW(2)) u_c (
    .CK(CK), .RESET(RESET), .EN(EN), .X(X), .LOAD_PAT(LOAD_PAT), .PAT_IN(PAT_IN[1:0]),
    .CLR_CNT(CLR_CNT), .Z(zc), .MATCH_CNT(cntc), .CNT_SAT(satc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after an edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic sample(input logic bit_in);
    EN = 1'b1;
    X  = bit_in;
    tick();
  endtask

  initial begin
    // Test 1: defaults, pattern 110
    RESET = 1'b1;
    tick();
    check("rst_z", za, 0);
    check("rst_cnt", cnta, 0);
    check("rst_sat", sata, 0);
    RESET = 1'b0;
    sample(1); check("t1_s1_z", za, 0);
    sample(1); check("t1_s2_z", za, 0);
    sample(0); check("t1_s3_z", za, 1);
    sample(1); check("t1_s4_z", za, 0);
    sample(1); check("t1_s5_z", za, 0);
    sample(0); check("t1_s6_z", za, 1);
    check("t1_cnt", cnta, 2);
    check("t1_b_cnt", cntb, 2);

    // Test 2: load 101 and clear counters; overlap vs non-overlap
    LOAD_PAT = 1'b1; PAT_IN = 3'b101; CLR_CNT = 1'b1; EN = 1'b1; X = 1'b1;
    tick();
    check("t2_load_z", za, 0);
    check("t2_clr_cnt", cnta, 0);
    LOAD_PAT = 1'b0; CLR_CNT = 1'b0;
    sample(1); check("t2_s1_a", za, 0);
    sample(0); check("t2_s2_a", za, 0);
    sample(1); check("t2_s3_a", za, 1); check("t2_s3_b", zb, 1);
    sample(0); check("t2_s4_a", za, 0); check("t2_s4_b", zb, 0);
    sample(1); check("t2_s5_a", za, 1); check("t2_s5_b", zb, 0);
    check("t2_cnt_a", cnta, 2);
    check("t2_cnt_b", cntb, 1);

    // Test 3: EN gaps are transparent; X toggles during gaps must be ignored
    LOAD_PAT = 1'b1; PAT_IN = 3'b110; CLR_CNT = 1'b1;
    tick();
    LOAD_PAT = 1'b0; CLR_CNT = 1'b0;
    sample(1);
    EN = 1'b0; X = 1'b0; tick(); check("t3_gap1a", za, 0);
    tick(); check("t3_gap1b", za, 0);
    sample(1);
    EN = 1'b0; X = 1'b0; tick(); check("t3_gap2a", za, 0);
    X = 1'b1; tick(); check("t3_gap2b", za, 0);
    sample(0); check("t3_hit", za, 1);
    EN = 1'b0; tick(); check("t3_after", za, 0);
    check("t3_cnt", cnta, 1);

    // Test 4: load mid-stream discards history, counter untouched
    sample(1); check("t4_s1", za, 0);
    sample(1); check("t4_s2", za, 0);
    LOAD_PAT = 1'b1; PAT_IN = 3'b110;
    tick();
    check("t4_load_z", za, 0);
    check("t4_load_cnt", cnta, 1);
    LOAD_PAT = 1'b0;
    sample(0); check("t4_no_z", za, 0);
    sample(1); check("t4_r1", za, 0);
    sample(1); check("t4_r2", za, 0);
    sample(0); check("t4_r3", za, 1);
    check("t4_cnt", cnta, 2);

    // Test 5: narrow counter saturation with pattern 11, then clear on a hit
    RESET = 1'b1; EN = 1'b0;
    tick();
    check("t5_rst_cnt", cntc, 0);
    check("t5_rst_sat", satc, 0);
    RESET = 1'b0;
    sample(1); check("t5_s1_z", zc, 0); check("t5_s1_cnt", cntc, 0);
    sample(1); check("t5_s2_z", zc, 1); check("t5_s2_cnt", cntc, 1); check("t5_s2_sat", satc, 0);
    sample(1); check("t5_s3_cnt", cntc, 2); check("t5_s3_sat", satc, 0);
    sample(1); check("t5_s4_cnt", cntc, 3); check("t5_s4_sat", satc, 1);
    sample(1); check("t5_s5_cnt", cntc, 3); check("t5_s5_sat", satc, 1);
    sample(1); check("t5_s6_z", zc, 1); check("t5_s6_cnt", cntc, 3);
    CLR_CNT = 1'b1;
    sample(1); check("t5_clr_z", zc, 1); check("t5_clr_cnt", cntc, 0); check("t5_clr_sat", satc, 0);
    CLR_CNT = 1'b0;
    sample(1); check("t5_after_cnt", cntc, 1);

    // Test 6: reset mid-stream discards the partial 11 of pattern 110
    sample(1);
    sample(1);
    RESET = 1'b1; EN = 1'b1; X = 1'b1;
    tick();
    check("t6_rst_za", za, 0);
    check("t6_rst_zc", zc, 0);
    check("t6_rst_cntc", cntc, 0);
    check("t6_rst_satc", satc, 0);
    check("t6_rst_cnta", cnta, 0);
    RESET = 1'b0;
    sample(0); check("t6_no_z", za, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
